fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 2-source/2-stage forwarding logic in the EX stage.
- Generates per-operand bypass selects for NUM_SRC sources across FWD_STAGES downstream stages.
- Detects load-use hazards and tracks outstanding multi-cycle ops (mul/div, long loads) in a register scoreboard with one shared writeback slot.
- Drives the global pipeline stall and the multi-cycle writeback bus.

Parameters:
- REG_ADDR_W, 5: register address width; NUM_REGS = 2**REG_ADDR_W.
- NUM_SRC, 2: source operands checked per EX instruction.
- FWD_STAGES, 2: forwarding stages; index 0 = youngest (EX/MEM).
- MAX_LAT, 6: maximum multi-cycle latency, in cycles.
- LAT_W, 3: width of issue_lat; must satisfy 2**LAT_W > MAX_LAT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_rs_addr  in  NUM_SRC*REG_ADDR_W  EX source addresses, packed; source i at [i*REG_ADDR_W +: REG_ADDR_W].
- ex_rs_valid  in  NUM_SRC  source i is actually read.
- stage_rd  in  FWD_STAGES*REG_ADDR_W  destination register per stage, packed.
- stage_regwrite  in  FWD_STAGES  stage writes a register.
- stage_data_ready  in  FWD_STAGES  stage result exists now (0 for a load still in MEM).
- issue_valid  in  1  EX instruction is a multi-cycle op.
- issue_rd  in  REG_ADDR_W  its destination.
- issue_lat  in  LAT_W  its latency L, 1..MAX_LAT.
- fwd_sel  out  NUM_SRC*SEL_W  per-source select, SEL_W = clog2(FWD_STAGES+2). Codes: 0 = regfile; k+1 = stage k; FWD_STAGES+1 = multi-cycle writeback bus.
- stall  out  1  freeze IF/ID/EX this cycle.
- issue_accept  out  1  issue_valid && !stall.
- mc_wb_valid  out  1  multi-cycle result writes back this cycle (registered).
- mc_wb_rd  out  REG_ADDR_W  its destination (registered).

Behaviour:
- Reset (async, rst_n=0):
  - busy bits, completion reservations, pending destinations, mc_wb_valid, mc_wb_rd and the stall counter all clear to 0.
  - Combinational outputs follow the cleared state: fwd_sel=0, stall=0 when no inputs are asserted.
  - Reset mid-operation discards all outstanding ops; no wb pulse is produced for them.
- Issue accepted at cycle t with latency L:
  - busy[rd] is set from t+1.
  - mc_wb_valid=1 and mc_wb_rd=rd in cycle t+L.
  - busy[rd] clears at t+L+1.
  - Exactly one completion per cycle: each completion cycle is reserved at issue.
- Source resolution, per source i; only when ex_rs_valid[i]=1 and address != 0, otherwise sel=0 and no stall contribution. Priority order:
  - (a) Lowest k with stage_regwrite[k] and stage_rd[k]==addr: if stage_data_ready[k], sel=k+1; else load-use stall.
  - (b) Else, if mc_wb_valid and mc_wb_rd==addr: sel=FWD_STAGES+1.
  - (c) Else, if busy[addr]: stall.
  - (d) Else sel=0.
- Issue stall, when issue_valid=1 and any of:
  - busy[issue_rd] is set and that register is not completing this cycle (WAW);
  - completion cycle t+L is already reserved (writeback structural hazard).
- stall = OR of all source stalls and the issue stall.
- On stall, the scoreboard still advances (countdowns and writebacks proceed); only issue is blocked.
- issue_rd = 0: accepted and the completion cycle is reserved, but busy is never set and mc_wb_valid stays 0 for that slot.
- issue_lat = 0 or > MAX_LAT: illegal; the block clamps it into 1..MAX_LAT. Simulation assertion fires.
- Issue to a register completing in the same cycle: old op writes back; new op sets busy from t+1 with no gap.
- Timing: fwd_sel, stall and issue_accept are combinational from inputs and registered state. Scoreboard state is registered.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_loaduse_cnt[31:0], perf_scoreboard_cnt[31:0] and perf_wbslot_cnt[31:0].
  - Each counter increments, saturating at 2**32-1, on every cycle in which its cause contributes to stall. Causes: load-use (a), busy (c), and slot conflict.
  - All three reset to 0.
- When undefined: no counters and no extra ports.

Decomposition:
- Shared package (fwd_pkg) holds:
  - fwd_sel code constants: FWD_SEL_RF=0, stage base, FWD_SEL_MC.
  - SEL_W derivation function.
  - Stall-cause enum {NONE, LOADUSE, BUSY, WBSLOT}.
- One sub-module: fwd_scoreboard. It holds the busy bits, MAX_LAT-deep completion reservation shift register with pending destinations, and mc_wb outputs.
- The top keeps the per-source priority compare as a generate loop.

Test Plan:
- Stage 0: rd=5, regwrite=1, ready=1; src0=5 -> fwd_sel[0]=1, stall=0. Stages 0 and 1 both rd=5 -> stage 0 wins (sel=1).
- Load-use: stage 0 rd=7, ready=0; src1=7 -> stall=1. Next cycle, ready=1 -> sel[1]=1, stall=0. Repeat with src1=0 -> no stall.
- Issue rd=9, L=3 at t0 -> src=9 stalls at t0+1 and t0+2; at t0+3 mc_wb_valid=1, mc_wb_rd=9, sel=FWD_STAGES+1, no stall; t0+4 busy clear.
- Issue L=4 at t0, then L=3 at t0+1 (same completion cycle) -> second issue stalled, issue_accept=0 one cycle; accepted at t0+2; wb pulses at t0+4 and t0+5.
- Issue rd=3 L=2, then issue rd=3 at t0+1 -> WAW stall; re-issue at t0+2 accepted; no busy gap.
- Assert rst_n=0 with two ops outstanding -> all outputs 0 immediately; no mc_wb_valid after release. With FWD_HAZARD_PERF_EN, counters match stall cycles of each cause.

Source files
------------

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fwd_pkg
// Purpose  : Shared select codes, select-width helper and stall-cause enum.
// Revision : 1.0
// ============================================================================
package fwd_pkg;

    localparam int FWD_SEL_RF         = 0;
    localparam int FWD_SEL_STAGE_BASE = 1;

    function automatic int fwd_sel_w(input int fwd_stages);
        return $clog2(fwd_stages + 2);
    endfunction

    function automatic int fwd_sel_mc(input int fwd_stages);
        return fwd_stages + FWD_SEL_STAGE_BASE;
    endfunction

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_LOADUSE = 2'd1,
        CAUSE_BUSY    = 2'd2,
        CAUSE_WBSLOT  = 2'd3
    } stall_cause_e;

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Busy bits, completion-slot reservations and multi-cycle writeback.
// Revision : 1.0
// ============================================================================
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 6,
    parameter int LAT_W      = 3,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_fire_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [LAT_W-1:0]      issue_lat_i,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic                  slot_taken_o,
    output logic                  mc_wb_valid_o,
    output logic [REG_ADDR_W-1:0] mc_wb_rd_o
);

    // Entry k reserves the writeback in cycle now+k+1; the top entry is never
    // written but keeps the lookup uniform for L = MAX_LAT.
    logic [MAX_LAT-1:0]    resv_q, resv_d;
    logic [REG_ADDR_W-1:0] rd_q [MAX_LAT];
    logic [REG_ADDR_W-1:0] rd_d [MAX_LAT];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;

    always_comb begin
        slot_taken_o = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (issue_lat_i == LAT_W'(k + 1)) slot_taken_o = resv_q[k];
        end
    end

    always_comb begin
        resv_d = '0;
        for (int k = 0; k < MAX_LAT; k++) rd_d[k] = '0;
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            resv_d[k] = resv_q[k+1];
            rd_d[k]   = rd_q[k+1];
        end
        wb_valid_d = resv_q[0] && (rd_q[0] != '0);
        wb_rd_d    = wb_valid_d ? rd_q[0] : '0;
        busy_d     = busy_q;
        if (wb_valid_q) busy_d[wb_rd_q] = 1'b0;
        // Set after clear so a same-register reissue keeps busy without a gap.
        if (issue_fire_i) begin
            if (issue_rd_i != '0) busy_d[issue_rd_i] = 1'b1;
            if (issue_lat_i == LAT_W'(1)) begin
                wb_valid_d = (issue_rd_i != '0);
                wb_rd_d    = issue_rd_i;
            end else begin
                for (int k = 0; k < MAX_LAT - 1; k++) begin
                    if (issue_lat_i == LAT_W'(k + 2)) begin
                        resv_d[k] = 1'b1;
                        rd_d[k]   = issue_rd_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_q     <= '0;
            busy_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            for (int k = 0; k < MAX_LAT; k++) rd_q[k] <= '0;
        end else begin
            resv_q     <= resv_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            for (int k = 0; k < MAX_LAT; k++) rd_q[k] <= rd_d[k];
        end
    end

    assign busy_o        = busy_q;
    assign mc_wb_valid_o = wb_valid_q;
    assign mc_wb_rd_o    = wb_rd_q;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : EX bypass selects, load-use/scoreboard stalls, multi-cycle wb.
//            FWD_HAZARD_PERF_EN adds saturating stall-cause counters.
// Revision : 1.0
// ============================================================================
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int MAX_LAT    = 6,
    parameter int LAT_W      = 3,
    localparam int SEL_W     = fwd_sel_w(FWD_STAGES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    ex_rs_addr,
    input  logic [NUM_SRC-1:0]               ex_rs_valid,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd,
    input  logic [FWD_STAGES-1:0]            stage_regwrite,
    input  logic [FWD_STAGES-1:0]            stage_data_ready,
    input  logic                             issue_valid,
    input  logic [REG_ADDR_W-1:0]            issue_rd,
    input  logic [LAT_W-1:0]                 issue_lat,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic                             stall,
    output logic                             issue_accept,
    output logic                             mc_wb_valid,
    output logic [REG_ADDR_W-1:0]            mc_wb_rd
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                      perf_loaduse_cnt,
    output logic [31:0]                      perf_scoreboard_cnt,
    output logic [31:0]                      perf_wbslot_cnt
`endif
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int SEL_MC   = fwd_sel_mc(FWD_STAGES);

    logic [NUM_REGS-1:0] busy;
    logic                slot_taken;
    logic [LAT_W-1:0]    lat_eff;
    logic [NUM_SRC-1:0]  src_loaduse;
    logic [NUM_SRC-1:0]  src_busy;
    logic                waw_stall;
    logic                slot_stall;

    always_comb begin
        lat_eff = issue_lat;
        if (issue_lat == '0)                    lat_eff = LAT_W'(1);
        else if (issue_lat > LAT_W'(MAX_LAT))   lat_eff = LAT_W'(MAX_LAT);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_ADDR_W-1:0] addr;
        logic [SEL_W-1:0]      sel;
        stall_cause_e          cause;
        logic                  found;
        logic                  found_ready;
        logic [SEL_W-1:0]      found_sel;

        assign addr = ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];

        always_comb begin
            sel         = SEL_W'(FWD_SEL_RF);
            cause       = CAUSE_NONE;
            found       = 1'b0;
            found_ready = 1'b0;
            found_sel   = '0;
            if (ex_rs_valid[i] && (addr != '0)) begin
                for (int k = 0; k < FWD_STAGES; k++) begin
                    if (!found && stage_regwrite[k] &&
                        (stage_rd[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                        found       = 1'b1;
                        found_ready = stage_data_ready[k];
                        found_sel   = SEL_W'(k + FWD_SEL_STAGE_BASE);
                    end
                end
                if (found) begin
                    if (found_ready) sel = found_sel;
                    else             cause = CAUSE_LOADUSE;
                end else if (mc_wb_valid && (mc_wb_rd == addr)) begin
                    sel = SEL_W'(SEL_MC);
                end else if (busy[addr]) begin
                    cause = CAUSE_BUSY;
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] = sel;
        assign src_loaduse[i]            = (cause == CAUSE_LOADUSE);
        assign src_busy[i]               = (cause == CAUSE_BUSY);
    end

    assign waw_stall    = issue_valid && busy[issue_rd] &&
                          !(mc_wb_valid && (mc_wb_rd == issue_rd));
    assign slot_stall   = issue_valid && slot_taken;
    assign stall        = (|src_loaduse) || (|src_busy) || waw_stall || slot_stall;
    assign issue_accept = issue_valid && !stall;

    fwd_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_LAT    (MAX_LAT),
        .LAT_W      (LAT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_fire_i  (issue_accept),
        .issue_rd_i    (issue_rd),
        .issue_lat_i   (lat_eff),
        .busy_o        (busy),
        .slot_taken_o  (slot_taken),
        .mc_wb_valid_o (mc_wb_valid),
        .mc_wb_rd_o    (mc_wb_rd)
    );

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_sb_q, perf_ws_q;

    // WAW is a busy-bit hazard, so it is accounted with the scoreboard cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
            perf_ws_q <= '0;
        end else begin
            if ((|src_loaduse) && (perf_lu_q != '1))            perf_lu_q <= perf_lu_q + 32'd1;
            if (((|src_busy) || waw_stall) && (perf_sb_q != '1)) perf_sb_q <= perf_sb_q + 32'd1;
            if (slot_stall && (perf_ws_q != '1))                 perf_ws_q <= perf_ws_q + 32'd1;
        end
    end

    assign perf_loaduse_cnt    = perf_lu_q;
    assign perf_scoreboard_cnt = perf_sb_q;
    assign perf_wbslot_cnt     = perf_ws_q;
`endif

`ifndef SYNTHESIS
    a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid |-> ((issue_lat != '0) && (issue_lat <= LAT_W'(MAX_LAT))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Random stimulus against an op-list reference model with a
//            queue scoreboard; FWD_HAZARD_PERF_EN also checks the counters.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 2;
    localparam int MAX_LAT    = 6;
    localparam int LAT_W      = 3;
    localparam int SEL_W      = 2;
    localparam int N_CYCLES   = 4000;
    localparam int RST_AT     = 2100;

    typedef struct packed {
        logic [NUM_SRC*SEL_W-1:0] sel;
        logic                     stall;
        logic                     acc;
        logic                     wbv;
        logic [REG_ADDR_W-1:0]    wbrd;
    } exp_t;

    typedef struct {
        int rd;
        int done;
    } op_t;

    logic                             clk = 1'b0;
    logic                             rst_n;
    logic [NUM_SRC*REG_ADDR_W-1:0]    ex_rs_addr;
    logic [NUM_SRC-1:0]               ex_rs_valid;
    logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd;
    logic [FWD_STAGES-1:0]            stage_regwrite;
    logic [FWD_STAGES-1:0]            stage_data_ready;
    logic                             issue_valid;
    logic [REG_ADDR_W-1:0]            issue_rd;
    logic [LAT_W-1:0]                 issue_lat;
    logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
    logic                             stall;
    logic                             issue_accept;
    logic                             mc_wb_valid;
    logic [REG_ADDR_W-1:0]            mc_wb_rd;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_loaduse_cnt, perf_scoreboard_cnt, perf_wbslot_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_lu  = 0;
    int   m_sb  = 0;
    int   m_ws  = 0;
    exp_t exp_q[$];
    op_t  ops[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_SRC    (NUM_SRC),
        .FWD_STAGES (FWD_STAGES),
        .MAX_LAT    (MAX_LAT),
        .LAT_W      (LAT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_rs_addr       (ex_rs_addr),
        .ex_rs_valid      (ex_rs_valid),
        .stage_rd         (stage_rd),
        .stage_regwrite   (stage_regwrite),
        .stage_data_ready (stage_data_ready),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_lat        (issue_lat),
        .fwd_sel          (fwd_sel),
        .stall            (stall),
        .issue_accept     (issue_accept),
        .mc_wb_valid      (mc_wb_valid),
        .mc_wb_rd         (mc_wb_rd)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_loaduse_cnt    (perf_loaduse_cnt),
        .perf_scoreboard_cnt (perf_scoreboard_cnt),
        .perf_wbslot_cnt     (perf_wbslot_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_busy(input int r);
        if (r == 0) return 1'b0;
        foreach (ops[j]) if (ops[j].rd == r && ops[j].done >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_slot(input int lat);
        foreach (ops[j]) if (ops[j].done == cyc + lat) return 1'b1;
        return 1'b0;
    endfunction

    task automatic zero_inputs();
        ex_rs_addr = '0; ex_rs_valid = '0; stage_rd = '0;
        stage_regwrite = '0; stage_data_ready = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_lat = LAT_W'(1);
    endtask

    task automatic step();
        exp_t e;
        int   addr, lat, ird;
        bit   any_lu, any_busy, waw, slot, found;
        e = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] = REG_ADDR_W'($urandom_range(0, 7));
            ex_rs_valid[i] = ($urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < FWD_STAGES; k++) begin
            stage_rd[k*REG_ADDR_W +: REG_ADDR_W] = REG_ADDR_W'($urandom_range(0, 7));
            stage_regwrite[k]   = $urandom_range(0, 1) != 0;
            stage_data_ready[k] = $urandom_range(0, 3) != 0;
        end
        ird         = int'($urandom_range(0, 7));
        lat         = int'($urandom_range(1, MAX_LAT));
        issue_valid = ($urandom_range(0, 4) < 2);
        issue_rd    = REG_ADDR_W'(ird);
        issue_lat   = LAT_W'(lat);

        for (int j = ops.size() - 1; j >= 0; j--) if (ops[j].done < cyc) ops.delete(j);
        foreach (ops[j]) if (ops[j].done == cyc && ops[j].rd != 0) begin
            e.wbv  = 1'b1;
            e.wbrd = REG_ADDR_W'(ops[j].rd);
        end

        any_lu = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            addr  = int'(ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]);
            found = 1'b0;
            if (ex_rs_valid[i] && addr != 0) begin
                for (int k = 0; k < FWD_STAGES; k++) begin
                    if (!found && stage_regwrite[k] &&
                        int'(stage_rd[k*REG_ADDR_W +: REG_ADDR_W]) == addr) begin
                        found = 1'b1;
                        if (stage_data_ready[k]) e.sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        else                     any_lu = 1'b1;
                    end
                end
                if (!found) begin
                    if (e.wbv && int'(e.wbrd) == addr) e.sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_STAGES + 1);
                    else if (model_busy(addr))         any_busy = 1'b1;
                end
            end
        end
        waw = issue_valid && model_busy(ird) && !(e.wbv && int'(e.wbrd) == ird);
        slot = issue_valid && model_slot(lat);
        e.stall = any_lu || any_busy || waw || slot;
        e.acc   = issue_valid && !e.stall;
        exp_q.push_back(e);

        if (any_lu)          m_lu++;
        if (any_busy || waw) m_sb++;
        if (slot)            m_ws++;
        if (e.acc) ops.push_back('{rd: ird, done: cyc + lat});
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fwd_sel", 32'(fwd_sel), 32'(e.sel));
            check("stall", 32'(stall), 32'(e.stall));
            check("issue_accept", 32'(issue_accept), 32'(e.acc));
            check("mc_wb_valid", 32'(mc_wb_valid), 32'(e.wbv));
            if (e.wbv) check("mc_wb_rd", 32'(mc_wb_rd), 32'(e.wbrd));
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_fwd_sel"}, 32'(fwd_sel), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_accept"}, 32'(issue_accept), 32'd0);
        check({tag, "_wb_valid"}, 32'(mc_wb_valid), 32'd0);
        check({tag, "_wb_rd"}, 32'(mc_wb_rd), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        for (int n = 0; n < N_CYCLES; n++) begin
            @(posedge clk);
            #1;
            if (n == RST_AT) begin
                zero_inputs();
                #2 rst_n = 1'b0;
                #1 check_quiet("async_reset");
                #2 rst_n = 1'b1;
                ops.delete();
                m_lu = 0; m_sb = 0; m_ws = 0;
                cyc++;
            end else begin
                step();
            end
        end
        @(posedge clk);
        #1 zero_inputs();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef FWD_HAZARD_PERF_EN
        check("perf_loaduse", perf_loaduse_cnt, 32'(m_lu));
        check("perf_scoreboard", perf_scoreboard_cnt, 32'(m_sb));
        check("perf_wbslot", perf_wbslot_cnt, 32'(m_ws));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
